// File: rtl/btb_next_pc.sv
// btb_next_pc: fetch-stage branch target buffer and next-PC selector.
// A direct-mapped BTB is looked up combinationally with PCF. A hit combined with
// PredictTaken redirects fetch to the stored target. Each prediction travels
// through D and E and is compared there with the resolved branch. A disagreement
// raises MispredictE and steers PCNextF to the corrected PC. Resolved taken
// branches write their target into the BTB.
// Optional feature: define BTB_INVALIDATE_NT_EN to make a resolved not-taken branch
// clear its matching BTB entry.
module btb_next_pc #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic        PredictTaken,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        FlushE,
    input  logic        BranchE,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchTargetE,
    output logic [31:0] PCNextF,
    output logic        BTBHitF,
    output logic        PredTakenF,
    output logic        MispredictE
);

    localparam int TAG_W = 32 - IDX_W - 2;

    // BTB storage
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];

    // D-stage prediction register
    logic        d_v_q, d_pred_taken_q;
    logic [31:0] d_pred_target_q, d_pc_q;

    // E-stage prediction register
    logic        e_v_q, e_pred_taken_q;
    logic [31:0] e_pred_target_q, e_pc_q;

    logic [IDX_W-1:0] idx_f, idx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    logic [31:0]      btb_target_f;
    logic             dir_miss, tgt_miss, btb_write;

    assign idx_f        = PCF[IDX_W+1:2];
    assign tag_f        = PCF[31:IDX_W+2];
    assign idx_e        = e_pc_q[IDX_W+1:2];
    assign tag_e        = e_pc_q[31:IDX_W+2];
    assign btb_target_f = target_q[idx_f];

    assign BTBHitF    = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign PredTakenF = BTBHitF && PredictTaken;

    // A valid E-stage branch mispredicts on a wrong direction, or when it is taken
    // and the carried target does not match the resolved one.
    assign dir_miss    = BranchTakenE != e_pred_taken_q;
    assign tgt_miss    = BranchTakenE && (e_pred_target_q != BranchTargetE);
    assign MispredictE = BranchE && e_v_q && (dir_miss || tgt_miss);
    assign btb_write   = BranchE && e_v_q && BranchTakenE;

    // Next-PC priority: mispredict redirect, then BTB-predicted target, then sequential.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        PCNextF = PCF + 32'd4;
        if (MispredictE) begin
            PCNextF = BranchTakenE ? BranchTargetE : (e_pc_q + 32'd4);
        end else if (PredTakenF) begin
            PCNextF = btb_target_f;
        end
    end

    // Next valid bits: a taken branch sets its entry; optionally a not-taken hit clears it.
    always_comb begin
        valid_d = valid_q;
        if (btb_write) begin
            valid_d[idx_e] = 1'b1;
        end
`ifdef BTB_INVALIDATE_NT_EN
        else if (BranchE && e_v_q && !BranchTakenE && (tag_q[idx_e] == tag_e)) begin
            valid_d[idx_e] = 1'b0;
        end
`endif
    end

    // Valid bits are the only BTB state that needs reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and target are written by resolved taken branches.
    // NOTE: the tag/target arrays have no reset; valid_q alone decides whether an entry is live.
    always_ff @(posedge clk) begin
        if (btb_write) begin
            tag_q[idx_e]    <= tag_e;
            target_q[idx_e] <= BranchTargetE;
        end
    end

    // F->D capture of the fetch prediction; flush beats stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_v_q           <= 1'b0;
            d_pred_taken_q  <= 1'b0;
            d_pred_target_q <= '0;
            d_pc_q          <= '0;
        end else if (FlushD) begin
            d_v_q          <= 1'b0;
            d_pred_taken_q <= 1'b0;
        end else if (!(StallF || StallD)) begin
            d_v_q           <= 1'b1;
            d_pred_taken_q  <= PredTakenF;
            d_pred_target_q <= btb_target_f;
            d_pc_q          <= PCF;
        end
    end

    // D->E advance every cycle unless E is flushed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_v_q           <= 1'b0;
            e_pred_taken_q  <= 1'b0;
            e_pred_target_q <= '0;
            e_pc_q          <= '0;
        end else if (FlushE) begin
            e_v_q          <= 1'b0;
            e_pred_taken_q <= 1'b0;
        end else begin
            e_v_q           <= d_v_q;
            e_pred_taken_q  <= d_pred_taken_q;
            e_pred_target_q <= d_pred_target_q;
            e_pc_q          <= d_pc_q;
        end
    end

endmodule

// File: tb/tb_btb_next_pc.sv
// Directed testbench for btb_next_pc (ENTRIES=16). Inputs change 1 ns after the
// rising edge and outputs are sampled 1 ns later, well away from the next edge.
module tb_btb_next_pc;

`ifdef BTB_INVALIDATE_NT_EN
    localparam bit INVAL = 1'b1;
`else
    localparam bit INVAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] PCF = 32'h0;
    logic        PredictTaken = 1'b0;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, FlushE = 1'b0;
    logic        BranchE = 1'b0, BranchTakenE = 1'b0;
    logic [31:0] BranchTargetE = 32'h0;
    logic [31:0] PCNextF;
    logic        BTBHitF, PredTakenF, MispredictE;

    int n_cmp = 0;
    int n_bad = 0;

    btb_next_pc #(.ENTRIES(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .PCF          (PCF),
        .PredictTaken (PredictTaken),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .BranchE      (BranchE),
        .BranchTakenE (BranchTakenE),
        .BranchTargetE(BranchTargetE),
        .PCNextF      (PCNextF),
        .BTBHitF      (BTBHitF),
        .PredTakenF   (PredTakenF),
        .MispredictE  (MispredictE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_f(input string tag, input logic hit, input logic ptk, input logic [31:0] nxt);
        check({tag, ".hit"}, 32'(BTBHitF), 32'(hit));
        check({tag, ".ptk"}, 32'(PredTakenF), 32'(ptk));
        check({tag, ".next"}, PCNextF, nxt);
    endtask

    task automatic check_mis(input string tag, input logic mis);
        check({tag, ".mis"}, 32'(MispredictE), 32'(mis));
    endtask

    // Advance to just after the next rising edge and return controls to idle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
        BranchE = 1'b0; BranchTakenE = 1'b0; BranchTargetE = 32'h0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic pt);
        PCF = pc;
        PredictTaken = pt;
    endtask

    task automatic branch(input logic taken, input logic [31:0] tgt);
        BranchE = 1'b1;
        BranchTakenE = taken;
        BranchTargetE = tgt;
    endtask

    initial begin
        // Reset asserted asynchronously, with a branch on the inputs.
        fetch(32'h100, 1'b1);
        branch(1'b1, 32'h900);
        #1 reset = 1'b1;
        #1;
        check_f("reset", 1'b0, 1'b0, 32'h104);
        check_mis("reset", 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        BranchE = 1'b0;

        // Cold miss.
        fetch(32'h100, 1'b1);
        #1 check_f("cold", 1'b0, 1'b0, 32'h104);

        next_cycle(); fetch(32'h104, 1'b0);

        // 0x100 reaches E unpredicted and resolves taken to 0x200; same-cycle lookup sees old contents.
        next_cycle(); fetch(32'h100, 1'b1); branch(1'b1, 32'h200); FlushD = 1'b1; FlushE = 1'b1;
        #1 check_mis("train", 1'b1);
        check_f("train", 1'b0, 1'b0, 32'h200);

        // Trained entry hits.
        next_cycle(); fetch(32'h100, 1'b1);
        #1 check_f("hit", 1'b1, 1'b1, 32'h200);

        next_cycle(); fetch(32'h200, 1'b0);
        #1 check_f("miss200", 1'b0, 1'b0, 32'h204);

        // Predicted-taken 0x100 resolves not-taken.
        next_cycle(); fetch(32'h204, 1'b0); branch(1'b0, 32'h0); FlushD = 1'b1; FlushE = 1'b1;
        #1 check_mis("dir", 1'b1);
        check("dir.next", PCNextF, 32'h104);

        next_cycle(); fetch(32'h100, 1'b1);
        #1 check_f("after_nt", !INVAL, !INVAL, INVAL ? 32'h104 : 32'h200);

        next_cycle(); fetch(32'h200, 1'b0);

        // Resolves taken to a different target.
        next_cycle(); fetch(32'h204, 1'b0); branch(1'b1, 32'h300); FlushD = 1'b1; FlushE = 1'b1;
        #1 check_mis("tgt", 1'b1);
        check("tgt.next", PCNextF, 32'h300);

        next_cycle(); fetch(32'h100, 1'b1);
        #1 check_f("retarget", 1'b1, 1'b1, 32'h300);

        // Same index, different tag.
        next_cycle(); fetch(32'h140, 1'b1);
        #1 check_f("alias", 1'b0, 1'b0, 32'h144);

        // Correct prediction: no mispredict.
        next_cycle(); fetch(32'h300, 1'b0); branch(1'b1, 32'h300);
        #1 check_mis("correct", 1'b0);
        check("correct.next", PCNextF, 32'h304);

        // Hit with a not-taken direction prediction falls through.
        next_cycle(); fetch(32'h100, 1'b0);
        #1 check_f("hit_nt", 1'b1, 1'b0, 32'h104);

        // StallD holds the predicted-taken 0x100 in D for an extra cycle.
        next_cycle(); fetch(32'h100, 1'b1);
        next_cycle(); fetch(32'h400, 1'b0); StallD = 1'b1;
        next_cycle(); fetch(32'h500, 1'b0);
        next_cycle(); fetch(32'h600, 1'b0); branch(1'b1, 32'h300);
        #1 check_mis("stalld", 1'b0);
        check("stalld.next", PCNextF, 32'h604);

        // FlushE removes the 0x100 prediction before it reaches E.
        next_cycle(); fetch(32'h100, 1'b1);
        #1 check_f("pre_flush", 1'b1, 1'b1, 32'h300);
        next_cycle(); fetch(32'h104, 1'b0); FlushE = 1'b1;
        next_cycle(); fetch(32'h700, 1'b0); branch(1'b1, 32'h900);
        #1 check_mis("flushe", 1'b0);
        check("flushe.next", PCNextF, 32'h704);
        next_cycle(); fetch(32'h100, 1'b1);
        #1 check_f("flushe_nowrite", 1'b1, 1'b1, 32'h300);

        // Sequential PC wraps modulo 2^32.
        next_cycle(); fetch(32'hFFFF_FFFC, 1'b1);
        #1 check_f("wrap", 1'b0, 1'b0, 32'h0);

        // Reset mid-stream with a mispredicting branch in E.
        next_cycle(); fetch(32'h100, 1'b1);
        next_cycle(); fetch(32'h104, 1'b0);
        next_cycle(); fetch(32'h100, 1'b1); branch(1'b1, 32'h800);
        #1 check_mis("pre_reset", 1'b1);
        check("pre_reset.next", PCNextF, 32'h800);
        #1 reset = 1'b1;
        #1 check_mis("mid_reset", 1'b0);
        check_f("mid_reset", 1'b0, 1'b0, 32'h104);
        @(posedge clk);
        #1;
        reset = 1'b0;
        BranchE = 1'b0;
        fetch(32'h100, 1'b1);
        #1 check_f("post_reset", 1'b0, 1'b0, 32'h104);
        check_mis("post_reset", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/btb_next_pc.md
# btb_next_pc

Fetch-stage branch target buffer and next-PC selector for the pipelined core. It looks up the fetch PC in a direct-mapped BTB and combines a hit with the 2-bit predictor's `PredictTaken` to choose the next PC. It carries each prediction down through Decode and Execute, compares it with the resolved branch in Execute, and raises `MispredictE` with a redirect PC. Resolved taken branches train the BTB.

## Interface
Parameters:
- `ENTRIES`, default 16: number of BTB entries; must be a power of 2, minimum 4.
- `IDX_W`, default `$clog2(ENTRIES)`: index width; derived, not overridden.

Ports:
- `clk` in 1: clock. `reset` in 1: reset, asynchronous, active-high.
- `PCF` in 32: current fetch PC (word aligned).
- `PredictTaken` in 1: direction prediction from the predictor FSM.
- `StallF` in 1: fetch stall; the F→D capture is suppressed.
- `StallD` in 1: hold the D-stage prediction register.
- `FlushD` in 1: clear the D-stage prediction register.
- `FlushE` in 1: clear the E-stage prediction register.
- `BranchE` in 1: the E-stage instruction is a conditional or unconditional branch.
- `BranchTakenE` in 1: resolved direction, valid only when `BranchE` is high.
- `BranchTargetE` in 32: resolved target.
- `PCNextF` out 32: next fetch PC.
- `BTBHitF` out 1: the BTB entry is valid and its tag matches `PCF`.
- `PredTakenF` out 1: `BTBHitF & PredictTaken`.
- `MispredictE` out 1: the E-stage branch was mispredicted; the hazard unit flushes D and E.

## Operation
- Storage per entry: `valid`, tag `PC[31:IDX_W+2]`, and target[31:0]. Index is `PC[IDX_W+1:2]`.
- Lookup is combinational from the registered arrays.
- `PCNextF` is selected by priority:
  - When `MispredictE` is high: `BranchTakenE ? BranchTargetE : PCE+4`.
  - Else when `PredTakenF` is high: the BTB target.
  - Else: `PCF+4`.
- All PC additions are modulo 2^32; wrap-around is allowed.
- Pipeline registers each hold {`pred_taken`, `pred_target`, `pc`, `v`}:
  - F→D captures the F values with `v=1` unless `StallF` or `StallD`.
  - D→E captures the D values every cycle.
  - `FlushD` or `FlushE` clears the corresponding `v` and `pred_taken`. Flush has priority over stall.
- `MispredictE` = `BranchE & vE & ((BranchTakenE != pred_takenE) | (BranchTakenE & pred_targetE != BranchTargetE))`.
  - When `BranchE` is high and `vE` is low, no mispredict is raised.
- BTB update happens at the clock edge when `BranchE & vE & BranchTakenE`: the entry at `pcE`'s index is written with `valid=1`, the tag, and `BranchTargetE`. This overwrites any aliased entry.
- A resolved not-taken branch does not modify the BTB unless the macro under Configuration is defined.

## Timing
- Reset (asynchronous) clears every `valid` bit and every `v`/`pred_taken` bit. While reset is held, `MispredictE=0`, `BTBHitF=0`, `PredTakenF=0`, and `PCNextF=PCF+4`.
- Reset asserted mid-operation drops all in-flight predictions; no BTB write happens on that edge.
- Lookup latency is 0 cycles (combinational).
- A prediction is checked 2 cycles after fetch, when it reaches E, in the same cycle `BranchE` is presented.
- A BTB update is visible to lookups from the cycle after the write edge. A same-cycle lookup at the written index sees the old contents.
- A mispredict and a fetch-stage prediction in the same cycle: the redirect wins and the F-stage prediction is discarded by the hazard unit's `FlushD`.
- `MispredictE` is combinational. It is not registered inside this block.

## Configuration
- `BTB_INVALIDATE_NT_EN`:
  - Defined: when `BranchE & vE & ~BranchTakenE` and the entry at `pcE`'s index has a matching tag, that entry's `valid` is cleared at the clock edge.
  - Undefined: not-taken branches never modify the BTB.

## Test plan
- Cold miss: reset, then `PCF=0x100` with `PredictTaken=1` → `BTBHitF=0`, `PredTakenF=0`, `PCNextF=0x104`.
- Train then hit:
  - Stimulus: branch at 0x100 resolves taken with target 0x200 (`BranchE=1`, `BranchTakenE=1`, `vE=1`, no prior prediction).
  - Required on resolve: `MispredictE=1`, `PCNextF=0x200`.
  - Required on a later fetch of 0x100 with `PredictTaken=1`: `BTBHitF=1`, `PCNextF=0x200`.
- Direction mispredict: the trained 0x100 is predicted taken, then resolves not-taken → `MispredictE=1`, `PCNextF=0x104`.
  - With `BTB_INVALIDATE_NT_EN` defined, the next fetch of 0x100 gives `BTBHitF=0`.
  - Without it, the next fetch gives `BTBHitF=1`.
- Wrong target: predicted taken to 0x200, resolves taken to 0x300 → `MispredictE=1`, `PCNextF=0x300`. The entry is updated and the next hit yields 0x300.
- Aliasing (ENTRIES=16): train 0x100 → 0x200, then fetch 0x140 (same index, different tag) → `BTBHitF=0`, `PCNextF=0x144`.
- Stall/flush:
  - Assert `StallD` over a predicted-taken fetch → the D register is held unchanged.
  - Assert `FlushE` with a branch in E → `MispredictE=0` and no BTB write.
  - Assert reset mid-stream → all outputs return to their reset values immediately.
